int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 143 ++++++++++++++
 tb/tb_int_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Edge-triggered interrupt controller: pending/mask registers, lowest-index dispatch, INT pulse, eret handshake.
// Optional eret timeout is compiled in with `define INT_TIMEOUT_EN.
module int_ctrl #(
    parameter int N_IRQ     = 8,
    parameter int INT_WIDTH = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_IRQ-1:0]         irq,
    input  logic                     mask_we,
    input  logic [N_IRQ-1:0]         mask_wdata,
    input  logic                     eret,
    output logic                     INT,
    output logic [$clog2(N_IRQ)-1:0] irq_id,
    output logic                     busy,
    output logic [N_IRQ-1:0]         pending,
    output logic                     timeout_flag
);
    localparam int ID_W = $clog2(N_IRQ);
    localparam int CW   = $clog2(INT_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ERET} state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] irq_q, irq_d;
    logic [N_IRQ-1:0] rise_q, rise_d;
    logic             armed_q, armed_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic             int_q, int_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_IRQ-1:0] active;
    logic [N_IRQ-1:0] clr;
    logic [ID_W-1:0]  sel;
`ifdef INT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             tflag_q, tflag_d;
`endif

    always_comb begin
        irq_d   = irq;
        armed_d = 1'b1;
        // The first edge after reset only primes irq_q, so a line already high is not an edge.
        rise_d  = armed_q ? (irq & ~irq_q) : '0;
        mask_d  = mask_we ? mask_wdata : mask_q;
        active  = pending_q & mask_q;
        sel     = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (active[i]) sel = ID_W'(i);
        end
        clr     = '0;
        state_d = state_q;
        int_d   = int_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
`ifdef INT_TIMEOUT_EN
        tmo_d   = tmo_q;
        tflag_d = tflag_q;
`endif
        case (state_q)
            IDLE: begin
                if (|active) begin
                    state_d  = ASSERT;
                    int_d    = 1'b1;
                    id_d     = sel;
                    clr[sel] = 1'b1;
                    cnt_d    = '0;
                end
            end
            ASSERT: begin
                if (cnt_q == CW'(INT_WIDTH - 1)) begin
                    state_d = WAIT_ERET;
                    int_d   = 1'b0;
`ifdef INT_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_ERET: begin
                if (eret) begin
                    state_d = IDLE;
`ifdef INT_TIMEOUT_EN
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    tflag_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // A new edge arriving on the bit being dispatched keeps it pending.
        pending_d = (pending_q & ~clr) | rise_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            rise_q    <= '0;
            armed_q   <= 1'b0;
            pending_q <= '0;
            mask_q    <= '1;
            int_q     <= 1'b0;
            id_q      <= '0;
            cnt_q     <= '0;
`ifdef INT_TIMEOUT_EN
            tmo_q     <= '0;
            tflag_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            rise_q    <= rise_d;
            armed_q   <= armed_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            int_q     <= int_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
`ifdef INT_TIMEOUT_EN
            tmo_q     <= tmo_d;
            tflag_q   <= tflag_d;
`endif
        end
    end

    assign INT     = int_q;
    assign irq_id  = id_q;
    assign busy    = (state_q != IDLE);
    assign pending = pending_q;
`ifdef INT_TIMEOUT_EN
    assign timeout_flag = tflag_q;
`else
    assign timeout_flag = 1'b0;
`endif
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: vector table of mask/irq patterns, directed corner sequences,
// and a monitor that pops the expected irq_id on every INT rising edge.
module tb_int_ctrl;
    localparam int N_IRQ     = 8;
    localparam int INT_WIDTH = 2;
    localparam int TIMEOUT   = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N_IRQ-1:0] irq = '0;
    logic             mask_we = 1'b0;
    logic [N_IRQ-1:0] mask_wdata = '0;
    logic             eret = 1'b0;
    logic             int_o;
    logic [2:0]       irq_id;
    logic             busy;
    logic [N_IRQ-1:0] pending;
    logic             timeout_flag;

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q[$];

    int_ctrl #(.N_IRQ(N_IRQ), .INT_WIDTH(INT_WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .eret(eret), .INT(int_o), .irq_id(irq_id), .busy(busy), .pending(pending),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_IRQ-1:0] pat;
        logic [N_IRQ-1:0] mask;
        logic [N_IRQ-1:0] left;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each INT rising edge must match the oldest expected id.
    logic int_prev = 1'b0;
    int   width = 0;
    always @(posedge clk) begin
        #1;
        if (int_o === 1'b1) begin
            if (!int_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_dispatch: got irq_id %0d expected none", irq_id);
                end else begin
                    logic [2:0] e;
                    e = exp_q.pop_front();
                    if (irq_id !== e) begin
                        errors++;
                        $display("FAIL dispatch_id: got %0d expected %0d", irq_id, e);
                    end
                end
            end
            width++;
        end else if (int_prev) begin
            chk("int_width", width, INT_WIDTH);
            width = 0;
        end
        int_prev = (int_o === 1'b1);
    end

    task automatic wait_int(input logic lvl, input int bound, input string name);
        int n = 0;
        while (int_o !== lvl && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (int_o !== lvl) begin
            errors++;
            $display("FAIL %s: INT=%b after %0d cycles, expected %b", name, int_o, n, lvl);
        end
    endtask

    task automatic serve();
        wait_int(1'b1, 12, "wait_int_rise");
        wait_int(1'b0, INT_WIDTH + 4, "wait_int_fall");
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("eret_to_idle", busy, 0);
    endtask

    task automatic write_mask(input logic [N_IRQ-1:0] m);
        mask_we = 1'b1;
        mask_wdata = m;
        step();
        mask_we = 1'b0;
    endtask

    task automatic pulse(input logic [N_IRQ-1:0] p);
        irq = p;
        step();
        irq = '0;
    endtask

    task automatic do_reset(input logic [N_IRQ-1:0] irq_at_release);
        reset = 1'b0;
        irq = irq_at_release;
        mask_we = 1'b0;
        eret = 1'b0;
        step();
        step();
        chk("rst_int", int_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_irq_id", irq_id, 0);
        chk("rst_timeout_flag", timeout_flag, 0);
        reset = 1'b1;
        step();
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{pat: 8'h81, mask: 8'hFF, left: 8'h00};
        vecs[1] = '{pat: 8'h3C, mask: 8'hF3, left: 8'h0C};
        vecs[2] = '{pat: 8'h40, mask: 8'h00, left: 8'h40};
        vecs[3] = '{pat: 8'hFF, mask: 8'h80, left: 8'h7F};

        do_reset('0);

        // Single source: latency, INT width, clearing of pending on dispatch.
        exp_q.push_back(3'd3);
        pulse(8'h08);
        step();
        chk("p3_pending", pending, 8'h08);
        chk("p3_int_low", int_o, 0);
        step();
        chk("p3_int_hi", int_o, 1);
        chk("p3_irq_id", irq_id, 3);
        chk("p3_pending_clr", pending, 8'h00);
        chk("p3_busy", busy, 1);
        step();
        chk("p3_int_hi2", int_o, 1);
        step();
        chk("p3_int_fall", int_o, 0);
        chk("p3_busy_wait", busy, 1);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("p3_idle", busy, 0);
        chk("p3_id_hold", irq_id, 3);

        // Simultaneous edges: lowest index first, fresh INT pulse for the second.
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd5);
        pulse(8'h22);
        serve();
        serve();

        // Table-driven mask/pattern vectors.
        for (int v = 0; v < 4; v++) begin
            write_mask(vecs[v].mask);
            pulse(vecs[v].pat);
            step();
            chk($sformatf("vec%0d_pending", v), pending, vecs[v].pat);
            chk($sformatf("vec%0d_int_low", v), int_o, 0);
            for (int b = 0; b < N_IRQ; b++) begin
                if (vecs[v].pat[b] && vecs[v].mask[b]) exp_q.push_back(3'(b));
            end
            for (int b = 0; b < N_IRQ; b++) begin
                if (vecs[v].pat[b] && vecs[v].mask[b]) serve();
            end
            step();
            step();
            chk($sformatf("vec%0d_left", v), pending, vecs[v].left);
            chk($sformatf("vec%0d_idle", v), busy, 0);
            write_mask(8'hFF);
            for (int b = 0; b < N_IRQ; b++) begin
                if (vecs[v].left[b]) exp_q.push_back(3'(b));
            end
            for (int b = 0; b < N_IRQ; b++) begin
                if (vecs[v].left[b]) serve();
            end
            chk($sformatf("vec%0d_drained", v), pending, 8'h00);
        end

        // Masked source stays pending, dispatches once unmasked.
        write_mask(8'hFB);
        pulse(8'h04);
        step();
        chk("m2_pending", pending, 8'h04);
        for (int i = 0; i < 4; i++) step();
        chk("m2_no_int", int_o, 0);
        chk("m2_not_busy", busy, 0);
        exp_q.push_back(3'd2);
        write_mask(8'hFF);
        serve();

        // eret during ASSERT ignored; re-edge during WAIT_ERET re-dispatches.
        exp_q.push_back(3'd3);
        pulse(8'h08);
        wait_int(1'b1, 12, "e3_rise");
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("e3_busy_assert", busy, 1);
        wait_int(1'b0, INT_WIDTH + 4, "e3_fall");
        step();
        chk("e3_still_wait", busy, 1);
        exp_q.push_back(3'd3);
        pulse(8'h08);
        step();
        chk("e3_repend", pending, 8'h08);
        chk("e3_busy", busy, 1);
        eret = 1'b1;
        step();
        eret = 1'b0;
        serve();

        // Asynchronous reset during WAIT_ERET with pending requests.
        exp_q.push_back(3'd4);
        pulse(8'h10);
        wait_int(1'b1, 12, "r_rise");
        wait_int(1'b0, INT_WIDTH + 4, "r_fall");
        pulse(8'h30);
        step();
        chk("r_pending", pending, 8'h30);
        #2;
        reset = 1'b0;
        #1;
        chk("r_async_int", int_o, 0);
        chk("r_async_pending", pending, 0);
        chk("r_async_busy", busy, 0);

        // irq already high at reset release is not an edge.
        do_reset(8'h01);
        step();
        step();
        chk("rel_no_edge", pending, 0);
        chk("rel_idle", busy, 0);
        irq = '0;
        step();

        // eret timeout behaviour.
        exp_q.push_back(3'd0);
        pulse(8'h01);
        wait_int(1'b1, 12, "t_rise");
        wait_int(1'b0, INT_WIDTH + 4, "t_fall");
`ifdef INT_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("t_busy_before", busy, 1);
        chk("t_flag_before", timeout_flag, 0);
        step();
        chk("t_idle", busy, 0);
        chk("t_flag", timeout_flag, 1);
        step();
        step();
        chk("t_flag_sticky", timeout_flag, 1);
`else
        for (int i = 0; i < 3 * TIMEOUT; i++) step();
        chk("t_busy_forever", busy, 1);
        chk("t_flag_zero", timeout_flag, 0);
        eret = 1'b1;
        step();
        eret = 1'b0;
        chk("t_eret_idle", busy, 0);
`endif

        step();
        step();
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end
endmodule
